// File: rtl/join2.sv
// join2: four-phase two-input join with FL/BL latency counters.
// Define JOIN2_SYNC_EN to pass in0_req, in1_req and out_ack through two-flop synchronizers.
module join2 #(
    parameter int WIDTH = 8,
    parameter int FL    = 2,
    parameter int BL    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in0_req,
    input  logic [WIDTH-1:0]   in0_data,
    output logic               in0_ack,
    input  logic               in1_req,
    input  logic [WIDTH-1:0]   in1_data,
    output logic               in1_ack,
    output logic               out_req,
    output logic [2*WIDTH-1:0] out_data,
    input  logic               out_ack
);
    localparam logic [7:0] FL8 = 8'(FL);
    localparam logic [7:0] BL8 = 8'(BL);
    typedef enum logic [2:0] {IDLE, FWD, SEND, RTZ, BACK} state_t;
    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       full_q, full_d, ack_q, ack_d, arm_q, arm_d, cap;
    logic             prim_q, prim_d, clear;
    logic [WIDTH-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0]       req_m, req_s;
    logic             oack_s;
`ifdef JOIN2_SYNC_EN
    logic [1:0] req_m_q, req_s_q;
    logic       oack_m_q, oack_s_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            req_m_q  <= '0;
            req_s_q  <= '0;
            oack_m_q <= 1'b0;
            oack_s_q <= 1'b0;
        end else begin
            req_m_q  <= {in1_req, in0_req};
            req_s_q  <= req_m_q;
            oack_m_q <= out_ack;
            oack_s_q <= oack_m_q;
        end
    assign req_m  = req_m_q;
    assign req_s  = req_s_q;
    assign oack_s = oack_s_q;
`else
    assign req_m  = {in1_req, in0_req};
    assign req_s  = req_m;
    assign oack_s = out_ack;
`endif
    // A sender must be seen idle (whole sync path low) after reset before its next req counts.
    always_comb begin
        prim_d  = 1'b1;
        cap     = ~full_q & req_s & ~ack_q & arm_q;
        ack_d   = cap | (ack_q & req_s);
        arm_d   = arm_q | ({2{prim_q}} & ~req_s & ~req_m);
        slot0_d = cap[0] ? in0_data : slot0_q;
        slot1_d = cap[1] ? in1_data : slot1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: if (&(full_q | cap)) begin
                state_d = FWD;
                cnt_d   = FL8;
            end
            FWD: if (cnt_q == 8'd0) state_d = SEND;
                 else cnt_d = cnt_q - 8'd1;
            SEND: if (oack_s) state_d = RTZ;
            RTZ: if (!oack_s) begin
                state_d = BACK;
                cnt_d   = BL8;
                clear   = 1'b1;
            end
            BACK: if (cnt_q == 8'd0) state_d = IDLE;
                  else cnt_d = cnt_q - 8'd1;
            default: state_d = IDLE;
        endcase
        full_d = clear ? 2'b00 : (full_q | cap);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            full_q  <= '0;
            ack_q   <= '0;
            arm_q   <= '0;
            prim_q  <= 1'b0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            ack_q   <= ack_d;
            arm_q   <= arm_d;
            prim_q  <= prim_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    assign in0_ack  = ack_q[0];
    assign in1_ack  = ack_q[1];
    assign out_req  = (state_q == SEND);
    assign out_data = {slot1_q, slot0_q};
endmodule

// File: tb/tb_join2.sv
// tb_join2: scenario tasks for join2 with an expected-token scoreboard.
module tb_join2;
    localparam int W  = 8;
    localparam int FL = 2;
    localparam int BL = 8;
`ifdef JOIN2_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif
    logic           clk = 0, reset = 0, in0_req = 0, in1_req = 0, out_ack = 0;
    logic [W-1:0]   in0_data = 0, in1_data = 0;
    logic           in0_ack, in1_ack, out_req;
    logic [2*W-1:0] out_data;
    int             cyc = 0, vectors = 0, miscompares = 0;
    logic [15:0]    exp_q[$];

    join2 #(.WIDTH(W), .FL(FL), .BL(BL)) dut (
        .clk(clk), .reset(reset),
        .in0_req(in0_req), .in0_data(in0_data), .in0_ack(in0_ack),
        .in1_req(in1_req), .in1_data(in1_data), .in1_ack(in1_ack),
        .out_req(out_req), .out_data(out_data), .out_ack(out_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; cap is the cycle count when ack is first seen, -1 on timeout.
    task automatic send(input int i, input logic [W-1:0] d, output int cap);
        int n;
        if (i == 0) begin in0_data = d; in0_req = 1; end
        else begin in1_data = d; in1_req = 1; end
        cap = -1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if ((i == 0 ? in0_ack : in1_ack) === 1'b1) begin cap = cyc; break; end
        end
        if (i == 0) in0_req = 0; else in1_req = 0;
        for (n = 0; n < 100 && (i == 0 ? in0_ack : in1_ack) !== 1'b0; n++) @(negedge clk);
    endtask

    task automatic recv(input int dly, output logic [15:0] d, output int rise, output int fall,
                        output bit stable);
        int n, t;
        rise = -1; fall = -1; stable = 1; d = '0;
        for (n = 0; n < 200 && out_req !== 1'b1; n++) @(negedge clk);
        if (out_req !== 1'b1) return;
        rise = cyc;
        d = out_data;
        repeat (dly) begin
            @(negedge clk);
            if (out_req !== 1'b1 || out_data !== d) stable = 0;
        end
        out_ack = 1;
        t = cyc;
        for (n = 0; n < 100 && out_req !== 1'b0; n++) @(negedge clk);
        if (out_req === 1'b0) fall = cyc - t;
        if (out_data !== d) stable = 0;
        out_ack = 0;
    endtask

    task automatic test_reset;
        #2 reset = 1;
        #1;
        vectors++;
        if ({in0_ack, in1_ack, out_req, out_data} !== 19'b0) begin
            miscompares++;
            $display("FAIL reset_async got=%h exp=0", {in0_ack, in1_ack, out_req, out_data});
        end
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in0_ack, in1_ack, out_req, out_data} !== 19'b0) begin
            miscompares++;
            $display("FAIL reset_idle got=%h exp=0", {in0_ack, in1_ack, out_req, out_data});
        end
    endtask

    task automatic test_scenario1;
        int t0, c0, c1, r, f;
        logic [15:0] d, e;
        bit st;
        exp_q.push_back(16'h3412);
        t0 = cyc;
        send(0, 8'h12, c0);
        vectors++;
        if (c0 - t0 !== 1 + S) begin miscompares++; $display("FAIL s1_ack0_lat got=%0d exp=%0d", c0 - t0, 1 + S); end
        repeat (3) @(negedge clk);
        t0 = cyc;
        send(1, 8'h34, c1);
        vectors++;
        if (c1 - t0 !== 1 + S) begin miscompares++; $display("FAIL s1_ack1_lat got=%0d exp=%0d", c1 - t0, 1 + S); end
        recv(0, d, r, f, st);
        e = exp_q.pop_front();
        vectors++;
        if (r - c1 !== FL + 1) begin miscompares++; $display("FAIL s1_fwd_lat got=%0d exp=%0d", r - c1, FL + 1); end
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL s1_data got=%h exp=%h", d, e); end
        vectors++;
        if (f !== 1 + S) begin miscompares++; $display("FAIL s1_req_fall got=%0d exp=%0d", f, 1 + S); end
        repeat (BL + 6 + S) @(negedge clk);
    endtask

    task automatic test_single_stall;
        int t0, c, r, f, n;
        logic [15:0] d, e;
        bit st, hi, ak;
        t0 = cyc;
        send(0, 8'hAA, c);
        vectors++;
        if (c - t0 !== 1 + S) begin miscompares++; $display("FAIL s2_ack_lat got=%0d exp=%0d", c - t0, 1 + S); end
        out_ack = 1;
        repeat (3) @(negedge clk);
        out_ack = 0;
        in0_data = 8'hBB; in0_req = 1;
        hi = 0; ak = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_req !== 1'b0) hi = 1;
            if (in0_ack !== 1'b0) ak = 1;
        end
        vectors++;
        if (hi !== 1'b0) begin miscompares++; $display("FAIL s2_no_out_req got=%b exp=0", hi); end
        vectors++;
        if (ak !== 1'b0) begin miscompares++; $display("FAIL s2_stall_ack got=%b exp=0", ak); end
        exp_q.push_back(16'hCCAA);
        send(1, 8'hCC, c);
        recv(0, d, r, f, st);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL s2_data got=%h exp=%h", d, e); end
        t0 = cyc;
        for (n = 0; n < 50 && in0_ack !== 1'b1; n++) @(negedge clk);
        vectors++;
        if (cyc - t0 !== 2 + S || in0_ack !== 1'b1) begin
            miscompares++; $display("FAIL s2_back_capture got=%0d exp=%0d", cyc - t0, 2 + S);
        end
        in0_req = 0;
        for (n = 0; n < 50 && in0_ack !== 1'b0; n++) @(negedge clk);
        exp_q.push_back(16'hDDBB);
        send(1, 8'hDD, c);
        recv(0, d, r, f, st);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL s2_data2 got=%h exp=%h", d, e); end
        repeat (BL + 6 + S) @(negedge clk);
    endtask

    task automatic test_simultaneous;
        int t0, n, r, f;
        logic [15:0] d, e;
        bit st, same;
        exp_q.push_back(16'h0201);
        in0_data = 8'h01; in1_data = 8'h02;
        in0_req = 1; in1_req = 1;
        same = 1; t0 = cyc;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in0_ack !== in1_ack) same = 0;
            if (in0_ack === 1'b1 && in1_ack === 1'b1) break;
        end
        vectors++;
        if (same !== 1'b1 || in0_ack !== 1'b1) begin
            miscompares++; $display("FAIL s3_same_edge got=%b%b exp=11", in0_ack, in1_ack);
        end
        vectors++;
        if (cyc - t0 !== 1 + S) begin miscompares++; $display("FAIL s3_ack_lat got=%0d exp=%0d", cyc - t0, 1 + S); end
        in0_req = 0; in1_req = 0;
        recv(0, d, r, f, st);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL s3_data got=%h exp=%h", d, e); end
        repeat (BL + 6 + S) @(negedge clk);
    endtask

    task automatic test_slow_ack;
        int t0, c, r, f;
        logic [15:0] d, e;
        bit st;
        exp_q.push_back(16'hBC9A);
        send(0, 8'h9A, c);
        send(1, 8'hBC, c);
        in0_data = 8'h11; in0_req = 1;
        in1_data = 8'h22; in1_req = 1;
        recv(10, d, r, f, st);
        e = exp_q.pop_front();
        vectors++;
        if (st !== 1'b1) begin miscompares++; $display("FAIL s4_stable got=%b exp=1", st); end
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL s4_data got=%h exp=%h", d, e); end
        vectors++;
        if ({in0_ack, in1_ack} !== 2'b00) begin
            miscompares++; $display("FAIL s4_held_full got=%b%b exp=00", in0_ack, in1_ack);
        end
        t0 = cyc;
        exp_q.push_back(16'h2211);
        recv(0, d, r, f, st);
        e = exp_q.pop_front();
        in0_req = 0; in1_req = 0;
        vectors++;
        if (r - t0 !== BL + FL + 4 + S || r - t0 < BL) begin
            miscompares++; $display("FAIL s4_join_gap got=%0d exp=%0d", r - t0, BL + FL + 4 + S);
        end
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL s4_data2 got=%h exp=%h", d, e); end
        repeat (BL + 6 + S) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int c, n, r, f;
        logic [15:0] d, e;
        bit st, seen;
        send(0, 8'h77, c);
        send(1, 8'h88, c);
        for (n = 0; n < 50 && out_req !== 1'b1; n++) @(negedge clk);
        in0_data = 8'h99; in0_req = 1;
        @(negedge clk);
        #2 reset = 1;
        #1;
        vectors++;
        if ({in0_ack, in1_ack, out_req, out_data} !== 19'b0) begin
            miscompares++; $display("FAIL s5_async_reset got=%h exp=0", {in0_ack, in1_ack, out_req, out_data});
        end
        @(negedge clk);
        reset = 0;
        seen = 0;
        repeat (8) begin @(negedge clk); if (in0_ack !== 1'b0) seen = 1; end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL s5_stale_req got=%b exp=0", seen); end
        in0_req = 0;
        repeat (4) @(negedge clk);
        exp_q.push_back(16'h6655);
        send(0, 8'h55, c);
        send(1, 8'h66, c);
        recv(0, d, r, f, st);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL s5_data got=%h exp=%h", d, e); end
    endtask

    initial begin
        test_reset;
        test_scenario1;
        test_single_stall;
        test_simultaneous;
        test_slow_ack;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
